// File: rtl/lifo_stack_ctl_if.sv
// Request/response bundle for lifo_stack_ctl: push/pop/flush controls in, pop data and status out.
// The master drives requests; the slave (the stack) returns data and occupancy flags.
interface lifo_stack_ctl_if #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 128
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic             clear;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, d, clear, err_clr,
    input  q, q_valid, count, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  push, pop, d, clear, err_clr,
    output q, q_valid, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack_ctl.sv
// LIFO stack with registered pop data; pop data valid one cycle after the pop edge.
// No backpressure: push when full / pop when empty are dropped and latched as sticky errors.
module lifo_stack_ctl #(
  parameter int WIDTH    = 11,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = 120
) (
  input  logic              clk,
  input  logic              reset,
  lifo_stack_ctl_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             do_swap;
  logic             do_bypass;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             unf_set;

  always_comb begin
    is_empty  = (count_r == '0);
    is_full   = (count_r == CW'(DEPTH));
    top_idx   = AW'(count_r - CW'(1));
    wr_idx    = AW'(count_r);

    // clear outranks every request; simultaneous push+pop never moves count
    do_swap   = !bus.clear && bus.push && bus.pop && !is_empty;
    do_bypass = !bus.clear && bus.push && bus.pop &&  is_empty;
    do_push   = !bus.clear && bus.push && !bus.pop && !is_full;
    do_pop    = !bus.clear && bus.pop && !bus.push && !is_empty;
    ovf_set   = !bus.clear && bus.push && !bus.pop && is_full;
    unf_set   = !bus.clear && bus.pop && !bus.push && is_empty;
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (do_swap) begin
      mem[top_idx] <= bus.d;
    end else if (do_push) begin
      mem[wr_idx] <= bus.d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r     <= '0;
      q_r         <= '0;
      q_valid_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      q_valid_r <= do_swap || do_bypass || do_pop;

      if (bus.clear) begin
        count_r <= '0;
      end else if (do_push) begin
        count_r <= count_r + CW'(1);
      end else if (do_pop) begin
        count_r <= count_r - CW'(1);
      end

      if (do_swap || do_pop) begin
        q_r <= mem[top_idx];
      end else if (do_bypass) begin
        q_r <= bus.d;
      end

      // a fresh error in the err_clr cycle leaves the flag set
      overflow_r  <= (overflow_r  && !bus.err_clr) || ovf_set;
      underflow_r <= (underflow_r && !bus.err_clr) || unf_set;
    end
  end

  always_comb begin
    bus.q           = q_r;
    bus.q_valid     = q_valid_r;
    bus.count       = count_r;
    bus.empty       = is_empty;
    bus.full        = is_full;
    bus.almost_full = (int'(count_r) >= AF_LEVEL);
    bus.overflow    = overflow_r;
    bus.underflow   = underflow_r;
  end
endmodule

// File: tb/tb_lifo_stack_ctl.sv
// Randomised and directed bench for lifo_stack_ctl against a queue-based stack model.
module tb_lifo_stack_ctl;
  localparam int WIDTH    = 11;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lifo_stack_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] stk [$];
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  logic             m_ov;
  logic             m_un;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_q  = '0;
    m_qv = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic check_all();
    check("count",       32'(bus.count),       32'(stk.size()));
    check("q",           32'(bus.q),           32'(m_q));
    check("q_valid",     32'(bus.q_valid),     32'(m_qv));
    check("empty",       32'(bus.empty),       32'(stk.size() == 0));
    check("full",        32'(bus.full),        32'(stk.size() == DEPTH));
    check("almost_full", 32'(bus.almost_full), 32'(stk.size() >= AF_LEVEL));
    check("overflow",    32'(bus.overflow),    32'(m_ov));
    check("underflow",   32'(bus.underflow),   32'(m_un));
  endtask

  // Stack semantics straight from the behaviour rules, on a queue.
  task automatic model_step(input logic pu, input logic po, input logic [WIDTH-1:0] dd,
                            input logic cl, input logic ec);
    logic ov_new, un_new;
    ov_new = 1'b0;
    un_new = 1'b0;
    m_qv   = 1'b0;
    if (cl) begin
      stk.delete();
    end else if (pu && po) begin
      m_qv = 1'b1;
      if (stk.size() == 0) begin
        m_q = dd;
      end else begin
        m_q = stk[stk.size()-1];
        stk[stk.size()-1] = dd;
      end
    end else if (pu) begin
      if (stk.size() < DEPTH) stk.push_back(dd);
      else ov_new = 1'b1;
    end else if (po) begin
      if (stk.size() > 0) begin
        m_q  = stk.pop_back();
        m_qv = 1'b1;
      end else begin
        un_new = 1'b1;
      end
    end
    m_ov = (m_ov && !ec) || ov_new;
    m_un = (m_un && !ec) || un_new;
  endtask

  task automatic step(input logic pu, input logic po, input logic [WIDTH-1:0] dd,
                      input logic cl, input logic ec);
    bus.push    = pu;
    bus.pop     = po;
    bus.d       = dd;
    bus.clear   = cl;
    bus.err_clr = ec;
    @(posedge clk);
    model_step(pu, po, dd, cl, ec);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int push_pct;
    logic pu, po, cl, ec;

    bus.push = 1'b0; bus.pop = 1'b0; bus.d = '0; bus.clear = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 11'h000, 0, 0);

    // LIFO order and almost_full
    step(1, 0, 11'h001, 0, 0);
    step(1, 0, 11'h002, 0, 0);
    step(1, 0, 11'h003, 0, 0);
    check("t1_af", 32'(bus.almost_full), 32'd1);
    step(0, 1, 11'h000, 0, 0);
    check("t1_pop0", 32'(bus.q), 32'h003);
    step(0, 1, 11'h000, 0, 0);
    step(0, 1, 11'h000, 0, 0);
    check("t1_pop2", 32'(bus.q), 32'h001);

    // overflow keeps the old top
    for (int i = 0; i < 4; i++) step(1, 0, WIDTH'(11'h010 + i), 0, 0);
    check("t2_full", 32'(bus.full), 32'd1);
    step(1, 0, 11'h7FF, 0, 0);
    check("t2_ovf", 32'(bus.overflow), 32'd1);
    step(0, 1, 11'h000, 0, 0);
    check("t2_top", 32'(bus.q), 32'h013);
    for (int i = 0; i < 3; i++) step(0, 1, 11'h000, 0, 0);

    // underflow, err_clr, err_clr racing a new error
    step(0, 1, 11'h000, 0, 0);
    check("t3_unf", 32'(bus.underflow), 32'd1);
    step(0, 0, 11'h000, 0, 1);
    step(0, 1, 11'h000, 0, 1);
    check("t3_unf_wins", 32'(bus.underflow), 32'd1);
    step(0, 0, 11'h000, 0, 1);

    // top replace and empty bypass
    step(1, 0, 11'h0A0, 0, 0);
    step(1, 0, 11'h0B0, 0, 0);
    step(1, 1, 11'h0C0, 0, 0);
    check("t4_swap_q", 32'(bus.q), 32'h0B0);
    step(0, 1, 11'h000, 0, 0);
    check("t4_swap_next", 32'(bus.q), 32'h0C0);
    step(0, 1, 11'h000, 0, 0);
    step(1, 1, 11'h055, 0, 0);
    check("t4_bypass", 32'(bus.q), 32'h055);

    // flush beats push, then a mid-cycle reset
    for (int i = 0; i < 3; i++) step(1, 0, WIDTH'(11'h100 + i), 0, 0);
    step(1, 0, 11'h177, 1, 0);
    check("t5_clear", 32'(bus.count), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 0, WIDTH'(11'h200 + i), 0, 0);
    step(0, 1, 11'h000, 0, 0);
    step(1, 0, 11'h300, 0, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 11'h000, 0, 0);

    // random traffic with phases biased toward full and toward empty
    for (int n = 0; n < 800; n++) begin
      push_pct = ((n / 40) % 2 == 0) ? 70 : 30;
      pu = ($urandom_range(99) < push_pct);
      po = ($urandom_range(99) < (100 - push_pct));
      cl = ($urandom_range(99) < 3);
      ec = ($urandom_range(99) < 6);
      step(pu, po, WIDTH'($urandom), cl, ec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
